run_sequencer: RTL and testbench

Upstream launcher for the processor core. Runs a fixed number of programs back-to-back. For each program it:
- pulses the core's reset,
- drives the core's start high and then low, which is what arms the core's run condition,
- waits for ack,
- reports the run's cycle count, or a timeout if ack never arrives.

Sits between the bench/host `go` request and the core's `reset`/`start`/`ack` ports.

---
 rtl/run_sequencer.sv | 155 +++++++++++++++
 tb/tb_run_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: launches NUM_PROGS programs back-to-back on the processor core.
// Each program pulses core_reset for 2 cycles, holds start for START_CYCLES
// cycles, then counts RUN cycles until ack (or abandons the run at TIMEOUT)
// and reports the count with a one-cycle result_valid pulse.
// Optional build macro SEQ_ACK_SYNC_EN: routes ack through a 2-flop
// synchronizer before any use; every reported count then grows by 2.
module run_sequencer #(
   parameter int NUM_PROGS    = 3,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 1024,
   parameter int CNT_W        = 16,
   parameter int IDX_W        = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic             ack,
   output logic             core_reset,
   output logic             start,
   output logic             busy,
   output logic [IDX_W-1:0] run_idx,
   output logic [CNT_W-1:0] cycles,
   output logic             result_valid,
   output logic             timeout,
   output logic             all_done
);

   // Phase counter spans the longer of CORE_RST (2 cycles) and START_HI.
   localparam int PH_W = (START_CYCLES > 2) ? $clog2(START_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CORE_RST,
      S_START_HI,
      S_RUN,
      S_REPORT,
      S_DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [PH_W-1:0]  phase;
   logic [CNT_W-1:0] run_cnt;
   logic             ack_use;

`ifdef SEQ_ACK_SYNC_EN
   logic [1:0] ack_sync;

   // Two-stage synchronizer so an ack from another clock domain is safe to use.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[0], ack};
      end
   end

   assign ack_use = ack_sync[1];
`else
   assign ack_use = ack;
`endif

   // State register; asynchronous clear drops core_reset and start at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         // NOTE: sequential state always uses non-blocking assignment so every
         // flop samples the pre-edge values regardless of statement order.
         state <= next_state;
      end
   end

   // Next-state decode and Moore outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path through
      // the block leaves it unassigned, which would infer a latch.
      next_state   = state;
      core_reset   = 1'b0;
      start        = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      all_done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) next_state = S_CORE_RST;
         end
         S_CORE_RST: begin
            core_reset = 1'b1;
            busy       = 1'b1;
            if (phase == PH_W'(1)) next_state = S_START_HI;
         end
         S_START_HI: begin
            start = 1'b1;
            busy  = 1'b1;
            if (phase == PH_W'(START_CYCLES - 1)) next_state = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            // ack and the limit in the same cycle both land in REPORT; the
            // datapath decides which one is recorded.
            if (ack_use || run_cnt == CNT_W'(TIMEOUT)) next_state = S_REPORT;
         end
         S_REPORT: begin
            busy         = 1'b1;
            result_valid = 1'b1;
            if (run_idx == IDX_W'(NUM_PROGS - 1)) next_state = S_DONE;
            else                                  next_state = S_CORE_RST;
         end
         S_DONE: begin
            all_done = 1'b1;
            // Waiting for go to drop keeps a held go from relaunching.
            if (!go) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Phase and run counters: both restart whenever their state is entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase   <= '0;
         run_cnt <= '0;
      end else begin
         if ((state == S_CORE_RST || state == S_START_HI) && next_state == state)
            phase <= phase + PH_W'(1);
         else
            phase <= '0;
         // Leaving RUN at the limit means the counter never passes TIMEOUT.
         if (state == S_RUN && next_state == S_RUN)
            run_cnt <= run_cnt + CNT_W'(1);
         else
            run_cnt <= '0;
      end
   end

   // Program index and the reported result; both hold outside their update points.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_idx <= '0;
         cycles  <= '0;
         timeout <= 1'b0;
      end else begin
         if (state == S_IDLE && next_state == S_CORE_RST)
            run_idx <= '0;
         else if (state == S_REPORT && next_state == S_CORE_RST)
            run_idx <= run_idx + IDX_W'(1);
         if (state == S_RUN && next_state == S_REPORT) begin
            cycles  <= run_cnt;
            timeout <= !ack_use;
         end
      end
   end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed and randomized checks of run_sequencer against a
// schedule-based reference model (TIMEOUT shortened to 8 for reachable limits).
module tb_run_sequencer;

   localparam int NUM_PROGS    = 3;
   localparam int START_CYCLES = 2;
   localparam int TIMEOUT      = 8;
   localparam int CNT_W        = 16;
   localparam int IDX_W        = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             go;
   logic             ack;
   logic             core_reset;
   logic             start;
   logic             busy;
   logic [IDX_W-1:0] run_idx;
   logic [CNT_W-1:0] cycles;
   logic             result_valid;
   logic             timeout;
   logic             all_done;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-program RUN cycle on which the core raises ack (0 = never).
   int lat [NUM_PROGS];
   int exp_idx;
   int exp_cycles;
   bit exp_to;
   bit noise;
   bit stale;

   always #5 clk = ~clk;

   run_sequencer #(
      .NUM_PROGS   (NUM_PROGS),
      .START_CYCLES(START_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (CNT_W),
      .IDX_W       (IDX_W)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .go          (go),
      .ack         (ack),
      .core_reset  (core_reset),
      .start       (start),
      .busy        (busy),
      .run_idx     (run_idx),
      .cycles      (cycles),
      .result_valid(result_valid),
      .timeout     (timeout),
      .all_done    (all_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string where, input bit cr, input bit st,
                             input bit bz, input bit rv, input bit ad);
      check({where, " core_reset"},   32'(core_reset),   32'(cr));
      check({where, " start"},        32'(start),        32'(st));
      check({where, " busy"},         32'(busy),         32'(bz));
      check({where, " result_valid"}, 32'(result_valid), 32'(rv));
      check({where, " all_done"},     32'(all_done),     32'(ad));
      check({where, " run_idx"},      32'(run_idx),      32'(exp_idx));
      check({where, " cycles"},       32'(cycles),       32'(exp_cycles));
      check({where, " timeout"},      32'(timeout),      32'(exp_to));
   endtask

   // ack outside RUN: held high for the stale case, junk under noise, else low.
   task automatic drive_other_ack();
      if (stale)      ack = 1'b1;
      else if (noise) ack = 1'($urandom_range(0, 1));
      else            ack = 1'b0;
   endtask

   task automatic drive_busy_go(input bit hold_go);
      if (hold_go)    go = 1'b1;
      else if (noise) go = 1'($urandom_range(0, 1));
      else            go = 1'b0;
   endtask

   // Launch from IDLE and check every cycle against the timing schedule.
   // abort_prog/abort_k select a RUN cycle at which reset is asserted instead.
   task automatic run_programs(input bit hold_go, input int abort_prog, input int abort_k);
      int l_eff;
      int run_len;
      go = 1'b1;
      drive_other_ack();
      tick();
      for (int p = 0; p < NUM_PROGS; p++) begin
         exp_idx = p;
         l_eff   = stale ? 1 : lat[p];
         // RUN lasts until ack, or TIMEOUT+1 cycles when the limit is hit.
         run_len = (l_eff == 0 || l_eff > TIMEOUT + 1) ? TIMEOUT + 1 : l_eff;
         for (int i = 0; i < 2; i++) begin
            expect_out("core_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            drive_busy_go(hold_go);
            drive_other_ack();
            tick();
         end
         for (int i = 0; i < START_CYCLES; i++) begin
            expect_out("start_hi", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            drive_busy_go(hold_go);
            drive_other_ack();
            tick();
         end
         for (int k = 1; k <= run_len; k++) begin
            expect_out("run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (p == abort_prog && k == abort_k) begin
               reset = 1'b0;
               #1;
               exp_idx    = 0;
               exp_cycles = 0;
               exp_to     = 1'b0;
               expect_out("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               return;
            end
            ack = stale || (l_eff != 0 && k >= l_eff);
            drive_busy_go(hold_go);
            tick();
         end
         exp_to     = (l_eff == 0 || l_eff - 1 > TIMEOUT);
         exp_cycles = exp_to ? TIMEOUT : l_eff - 1;
         expect_out("report", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         drive_busy_go(hold_go);
         drive_other_ack();
         tick();
      end
      expect_out("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (hold_go) begin
         repeat ($urandom_range(2, 4)) begin
            go = 1'b1;
            tick();
            expect_out("done_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end
      end
      go = 1'b0;
      drive_other_ack();
      tick();
      expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset      = 1'b0;
      go         = 1'b1;
      ack        = 1'b0;
      noise      = 1'b0;
      stale      = 1'b0;
      exp_idx    = 0;
      exp_cycles = 0;
      exp_to     = 1'b0;

      // Reset held with go high: everything stays cleared.
      repeat (3) begin
         tick();
         expect_out("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      reset = 1'b1;
      go    = 1'b0;
      tick();
      expect_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Nominal: ack on the 6th RUN cycle of every program.
      lat = '{6, 6, 6};
      run_programs(1'b0, -1, 0);

      // Ack never arrives: every run times out.
      lat = '{0, 0, 0};
      run_programs(1'b0, -1, 0);

      // Around the limit: one short of it, the tie with ack, one past it.
      lat = '{TIMEOUT, TIMEOUT + 1, TIMEOUT + 2};
      run_programs(1'b0, -1, 0);

      // Ack held high throughout.
      stale = 1'b1;
      run_programs(1'b0, -1, 0);
      stale = 1'b0;

      // go held high across the whole sequence and into DONE.
      lat = '{1, 3, 2};
      run_programs(1'b1, -1, 0);

      // Random latencies with junk ack outside RUN and random go while busy.
      noise = 1'b1;
      repeat (6) begin
         foreach (lat[i]) lat[i] = int'($urandom_range(0, TIMEOUT + 3));
         run_programs(1'b0, -1, 0);
      end

      // Reset during RUN of program 1, then a clean restart from index 0.
      lat = '{4, 4, 4};
      run_programs(1'b0, 1, 2);
      go  = 1'b1;
      ack = 1'b1;
      repeat (2) begin
         tick();
         expect_out("held_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      reset = 1'b1;
      go    = 1'b0;
      ack   = 1'b0;
      tick();
      expect_out("idle_after_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      noise = 1'b0;
      lat   = '{2, 5, 7};
      run_programs(1'b0, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
